// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
// Synchronous FIFO controller for a synchronous-write, registered-read memory
// array (1-cycle read latency). Converts valid/ready push and pop streams into
// array write/read controls and presents the array's read data as the head.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    push handshake, in_data is the pushed word
//   out_valid/out_ready  pop handshake, out_data is the head word
//   count                stored entries, 0..DEPTH
//   mem_write_en/addr/data, mem_read_addr   controls to the memory array
//   mem_read_data        registered read data from the array
// ---------------------------------------------------------------------------
module fifo_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int ADDR  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [ADDR:0]    count,
   output logic             mem_write_en,
   output logic [ADDR-1:0]  mem_write_addr,
   output logic [WIDTH-1:0] mem_write_data,
   output logic [ADDR-1:0]  mem_read_addr,
   input  logic [WIDTH-1:0] mem_read_data
);

   logic [ADDR-1:0] r_wr_ptr;
   logic [ADDR-1:0] r_rd_ptr;
   logic [ADDR:0]   r_count;
   logic            r_out_valid;

   logic            w_push;
   logic            w_pop;
   logic            w_fetch;
   logic [ADDR:0]   w_pending;

   // Full blocks pushes even when a pop happens in the same cycle.
   assign in_ready  = (r_count != (ADDR+1)'(DEPTH));
   assign w_push    = in_valid & in_ready;
   assign w_pop     = r_out_valid & out_ready;

   // Entries written but not yet loaded into the array's output register.
   assign w_pending = r_count - {{ADDR{1'b0}}, r_out_valid};

   // Fetch the next word when the head register is free or being popped.
   assign w_fetch   = (w_pending != '0) & (~r_out_valid | out_ready);

   assign mem_write_en   = w_push;
   assign mem_write_addr = r_wr_ptr;
   assign mem_write_data = in_data;

   // Without a fetch, keep re-reading the current head slot so the array's
   // registered output holds steady while the consumer stalls.
   assign mem_read_addr  = w_fetch ? r_rd_ptr : (r_rd_ptr - ADDR'(1));

   assign out_data  = mem_read_data;
   assign out_valid = r_out_valid;
   assign count     = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_push)  r_wr_ptr <= r_wr_ptr + ADDR'(1);
         if (w_fetch) r_rd_ptr <= r_rd_ptr + ADDR'(1);

         if (w_fetch)    r_out_valid <= 1'b1;
         else if (w_pop) r_out_valid <= 1'b0;

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (ADDR+1)'(1);
            2'b01:   r_count <= r_count - (ADDR+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int ADDR  = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [ADDR:0]    count;
   logic             mem_write_en;
   logic [ADDR-1:0]  mem_write_addr;
   logic [WIDTH-1:0] mem_write_data;
   logic [ADDR-1:0]  mem_read_addr;
   logic [WIDTH-1:0] mem_read_data;

   fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count),
      .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data), .mem_read_addr(mem_read_addr),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // Memory array: synchronous write, registered read, old data on collision.
   logic [WIDTH-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_write_addr] <= mem_write_data;
      mem_read_data <= mem[mem_read_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: an ordered list of pushed words, each tagged with the
   // edge it was written on. A word is visible once it is at least one edge
   // old and its predecessor has been popped (fetch may coincide with pop).
   typedef struct {
      logic [WIDTH-1:0] data;
      int               wedge;
   } ent_t;
   ent_t sbq[$];
   int   model_cnt = 0;
   int   wr_idx    = 0;
   int   last_pop  = 0;
   bit   push_flag = 1'b0;
   bit   mon_en    = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit head_visible();
      int av;
      if (sbq.size() == 0) return 1'b0;
      av = sbq[0].wedge + 1;
      if (last_pop > av) av = last_pop;
      return av <= cyc;
   endfunction

   // Monitor / scoreboard: compares and retires expected entries.
   always @(negedge clk) begin
      if (mon_en) begin
         bit exp_ov;
         bit pop;
         exp_ov = head_visible();
         chk("count", 32'(count), 32'(model_cnt));
         chk("in_ready", 32'(in_ready), 32'(model_cnt != DEPTH));
         chk("out_valid", 32'(out_valid), 32'(exp_ov));
         if (exp_ov) chk("out_data", 32'(out_data), 32'(sbq[0].data));
         chk("wr_en", 32'(mem_write_en), 32'(push_flag));
         if (push_flag) begin
            chk("wr_addr", 32'(mem_write_addr), 32'(wr_idx % DEPTH));
            chk("wr_data", 32'(mem_write_data), 32'(in_data));
         end
         pop = exp_ov && out_ready;
         if (pop) begin
            void'(sbq.pop_front());
            last_pop = cyc + 1;
         end
         if (push_flag) wr_idx++;
         model_cnt = model_cnt + int'(push_flag) - int'(pop);
      end
   end

   // One cycle of stimulus; the expected word is queued when the push is issued.
   task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit r);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      push_flag = v && (model_cnt != DEPTH);
      if (push_flag) sbq.push_back('{data: d, wedge: cyc + 1});
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      #10;
      rst_n = 1'b1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 mon_en = 1'b1;

      // Single push, stalled head held for several cycles
      step(1'b1, 8'hA5, 1'b0);
      repeat (7) step(1'b0, 8'h00, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b1);

      // Fill to full, extra push refused
      for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
      step(1'b1, 8'h05, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      // Drain from full
      repeat (7) step(1'b0, 8'h00, 1'b1);

      // Continuous push/pop across pointer wraps
      for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h10 + i), 1'b1);
      repeat (4) step(1'b0, 8'h00, 1'b1);

      // Full with simultaneous push attempt and pop
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
      step(1'b0, 8'h00, 1'b0);
      step(1'b1, 8'hEE, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      repeat (6) step(1'b0, 8'h00, 1'b1);

      // Asynchronous reset mid-stream with three entries stored
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
      repeat (2) step(1'b0, 8'h00, 1'b0);
      chk("pre_rst_count", 32'(count), 32'd3);
      @(posedge clk);
      #2;
      mon_en    = 1'b0;
      push_flag = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_wr_addr", 32'(mem_write_addr), 32'd0);
      chk("arst_rd_addr", 32'(mem_read_addr), 32'(DEPTH - 1));
      sbq.delete();
      model_cnt = 0;
      wr_idx    = 0;
      last_pop  = 0;
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      step(1'b1, 8'h77, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step(1'(($urandom % 4) != 0), 8'($urandom), 1'(($urandom % 3) != 0));
      repeat (10) step(1'b0, 8'h00, 1'b1);
      @(negedge clk);
      #1;
      chk("drained_model", 32'(sbq.size()), 32'd0);
      chk("drained_count", 32'(count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
